// File: rtl/eyeriss_pkg.sv
// Shared Eyeriss types and constants.
// Arbiter state encoding and router client indices.
package eyeriss_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int CLIENT_WGHT  = 0;
  localparam int CLIENT_IFMAP = 1;
  localparam int CLIENT_PSUM  = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first set request at or above ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_priority_pick
  import eyeriss_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IW-1:0]    idx_o,
  output logic             valid_o
);

  function automatic logic [IW-1:0] rot(
    input logic [IW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  assign valid_o = |req_i;

  // Walk from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx_o = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_i[rot(ptr_i, k)]) idx_o = rot(ptr_i, k);
    end
  end

  always_comb begin
    gnt_oh_o = '0;
    if (valid_o) gnt_oh_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/glb_read_arbiter.sv
// Round-robin GLB read-port arbiter with burst locking.
// Read data is broadcast; per-client valid trails the address by 1.
module glb_read_arbiter
  import eyeriss_pkg::*;
#(
  parameter int DATA_BITWIDTH     = 16,
  parameter int ADDR_BITWIDTH_GLB = 10,
  parameter int N_REQ             = 3,
  parameter int MAX_BURST         = 0,
  parameter int CNT_W             = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_REQ-1:0]                   req_i,
  input  logic [N_REQ*ADDR_BITWIDTH_GLB-1:0] addr_i,
  output logic [N_REQ-1:0]                   gnt_o,
  output logic [DATA_BITWIDTH-1:0]           rd_data_o,
  output logic [N_REQ-1:0]                   rd_valid_o,
  output logic                               glb_read_req_o,
  output logic [ADDR_BITWIDTH_GLB-1:0]       glb_r_addr_o,
  input  logic [DATA_BITWIDTH-1:0]           glb_r_data_i
);

  localparam int IW = idx_w(N_REQ);
  localparam int A  = ADDR_BITWIDTH_GLB;
  localparam bit PREEMPT = (MAX_BURST > 0);
  localparam logic [CNT_W-1:0] LAST_BEAT =
    CNT_W'(PREEMPT ? MAX_BURST - 1 : 0);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rd_valid_q;

  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [N_REQ-1:0] owner_oh;
  logic [N_REQ-1:0] others;
  logic             own_req;
  logic             burst_end;
  logic             release_c;
  logic [IW-1:0]    ptr_next;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_oh_o(pick_oh),
    .idx_o   (pick_idx),
    .valid_o (pick_any)
  );

  always_comb begin
    owner_oh = '0;
    owner_oh[owner_q] = 1'b1;
  end

  assign own_req = req_i[owner_q];
  assign others  = req_i & ~owner_oh;

  assign burst_end = PREEMPT
                  && (cnt_q == LAST_BEAT)
                  && (|others);

  assign release_c = !own_req || burst_end;

  assign ptr_next = (owner_q == IW'(N_REQ - 1))
                  ? '0
                  : owner_q + 1'b1;

  assign glb_read_req_o = (state_q == GRANT) && own_req;
  assign glb_r_addr_o   = addr_i[int'(owner_q)*A +: A];

  assign gnt_o      = gnt_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = glb_r_data_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (own_req && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Pointer rotates past the releasing owner.
        if (release_c) begin
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= owner_oh & {N_REQ{glb_read_req_o}};
    end
  end

endmodule

// File: tb/tb_glb_read_arbiter.sv
// Scoreboard bench for glb_read_arbiter: unlimited-burst and
// MAX_BURST=4 instances share stimulus, each with its own model.
module tb_glb_read_arbiter;

  localparam int N = 3;
  localparam int A = 10;
  localparam int D = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*A-1:0] addr = '0;

  logic [N-1:0] gnt0, gnt1, rv0, rv1;
  logic [D-1:0] rd0, rd1;
  logic [D-1:0] gd0 = '0;
  logic [D-1:0] gd1 = '0;
  logic         rq0, rq1;
  logic [A-1:0] ra0, ra1;

  always #5 clk = ~clk;

  glb_read_arbiter #(
    .DATA_BITWIDTH(D), .ADDR_BITWIDTH_GLB(A), .N_REQ(N),
    .MAX_BURST(0), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .reset(reset), .req_i(req), .addr_i(addr),
    .gnt_o(gnt0), .rd_data_o(rd0), .rd_valid_o(rv0),
    .glb_read_req_o(rq0), .glb_r_addr_o(ra0),
    .glb_r_data_i(gd0)
  );

  glb_read_arbiter #(
    .DATA_BITWIDTH(D), .ADDR_BITWIDTH_GLB(A), .N_REQ(N),
    .MAX_BURST(4), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .reset(reset), .req_i(req), .addr_i(addr),
    .gnt_o(gnt1), .rd_data_o(rd1), .rd_valid_o(rv1),
    .glb_read_req_o(rq1), .glb_r_addr_o(ra1),
    .glb_r_data_i(gd1)
  );

  function automatic logic [D-1:0] glbf(input logic [A-1:0] a);
    return {a[5:0], a} ^ 16'hA5C3;
  endfunction

  // GLB memory stand-in: 1-cycle read latency.
  always @(posedge clk) begin
    gd0 <= glbf(ra0);
    gd1 <= glbf(ra1);
  end

  typedef struct {
    logic [N-1:0] gnt;
    logic         rdreq;
    logic [A-1:0] addr;
    logic [N-1:0] rv;
    logic [D-1:0] rd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int passes = 0;
  int vcnt[2][N];

  task automatic chk(input string nm, input int m,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s dut%0d t=%0t got=%h exp=%h",
                  nm, m, $time, got, exp);
  endtask

  task automatic compare(input int m, input exp_t e,
                         input logic [N-1:0] g,
                         input logic rq,
                         input logic [A-1:0] ra,
                         input logic [N-1:0] rv,
                         input logic [D-1:0] rd);
    chk("gnt", m, 32'(g), 32'(e.gnt));
    chk("glb_req", m, 32'(rq), 32'(e.rdreq));
    if (e.rdreq) chk("glb_addr", m, 32'(ra), 32'(e.addr));
    chk("rd_valid", m, 32'(rv), 32'(e.rv));
    chk("valid_onehot", m, 32'($countones(rv) <= 1), 32'd1);
    if (e.rv != '0) chk("rd_data", m, 32'(rd), 32'(e.rd));
    for (int c = 0; c < N; c++) if (rv[c]) vcnt[m][c]++;
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) compare(0, q0.pop_front(),
                               gnt0, rq0, ra0, rv0, rd0);
    if (q1.size() > 0) compare(1, q1.pop_front(),
                               gnt1, rq1, ra1, rv1, rd1);
  end

  // Reference model: who holds the port, whose turn is next,
  // how many beats the holder has had, what returns next cycle.
  int maxb[2] = '{0, 4};
  bit m_busy[2];
  int m_own[2], m_ptr[2], m_cnt[2], m_pv[2];
  logic [D-1:0] m_pd[2];

  // Client agents: each wants rem[c] more words from base[c].
  int rem[N], served[N], base[N];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_busy[m] = 0; m_own[m] = 0; m_ptr[m] = 0;
      m_cnt[m] = 0; m_pv[m] = -1; m_pd[m] = '0;
    end
  endtask

  task automatic model_step(input int m, input logic [N-1:0] r,
                            input bit rdreq,
                            input logic [A-1:0] a);
    bit rel;
    int others;
    m_pv[m] = rdreq ? m_own[m] : -1;
    m_pd[m] = glbf(a);
    if (!m_busy[m]) begin
      for (int k = N - 1; k >= 0; k--)
        if (r[(m_ptr[m] + k) % N]) m_own[m] = (m_ptr[m] + k) % N;
      if (r != '0) begin
        m_busy[m] = 1;
        m_cnt[m] = 0;
      end
    end else begin
      others = 0;
      for (int c = 0; c < N; c++)
        if (c != m_own[m] && r[c]) others++;
      rel = !r[m_own[m]]
         || (maxb[m] > 0 && m_cnt[m] == maxb[m] - 1 && others > 0);
      if (r[m_own[m]] && m_cnt[m] < 255) m_cnt[m]++;
      if (rel) begin
        m_busy[m] = 0;
        m_ptr[m] = (m_own[m] + 1) % N;
      end
    end
  endtask

  task automatic cyc();
    logic [N-1:0] r;
    logic [N*A-1:0] a;
    exp_t e;
    bit rdq[2];
    logic [A-1:0] ea[2];
    int own0;
    r = '0;
    for (int c = 0; c < N; c++) begin
      if (rem[c] > 0) begin
        r[c] = 1'b1;
        a[c*A +: A] = A'(base[c] + served[c]);
      end else begin
        a[c*A +: A] = A'($urandom);
      end
    end
    req = r;
    addr = a;
    own0 = m_own[0];
    for (int m = 0; m < 2; m++) begin
      e.gnt = m_busy[m] ? N'(1 << m_own[m]) : '0;
      e.rdreq = m_busy[m] && r[m_own[m]];
      e.addr = a[m_own[m]*A +: A];
      e.rv = (m_pv[m] >= 0) ? N'(1 << m_pv[m]) : '0;
      e.rd = m_pd[m];
      rdq[m] = e.rdreq;
      ea[m] = e.addr;
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    if (reset) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m, r, rdq[m], ea[m]);
    if (rdq[0]) begin
      served[own0]++;
      rem[own0]--;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic agents_clear();
    for (int c = 0; c < N; c++) begin
      rem[c] = 0;
      served[c] = 0;
    end
  endtask

  int snap[N];

  initial begin
    model_reset();
    agents_clear();
    for (int c = 0; c < N; c++) base[c] = 0;
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < N; c++) vcnt[m][c] = 0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    run(3);
    reset = 1'b0;

    // single client, 9-word burst from address 0
    rem[0] = 9;
    run(14);
    chk("single_beats", 0, 32'(vcnt[0][0]), 32'd9);
    chk("single_beats", 1, 32'(vcnt[1][0]), 32'd9);

    // three-way contention, 3 words each
    agents_clear();
    base[0] = 100; base[1] = 200; base[2] = 300;
    for (int c = 0; c < N; c++) snap[c] = vcnt[0][c];
    for (int c = 0; c < N; c++) rem[c] = 3;
    run(20);
    for (int c = 0; c < N; c++)
      chk("contend_beats", 0, 32'(vcnt[0][c] - snap[c]), 32'd3);

    // fairness: client 0 holds, client 2 arrives mid-burst
    agents_clear();
    rem[0] = 1000;
    run(3);
    rem[2] = 2;
    run(15);
    rem[0] = 0;
    run(6);

    // preemption pressure, then client 0 alone
    agents_clear();
    rem[0] = 10;
    rem[1] = 10;
    run(40);
    rem[0] = 10;
    run(15);

    // reset during a 9-word burst
    agents_clear();
    base[0] = 500;
    rem[0] = 9;
    run(6);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    agents_clear();
    run(2);
    base[1] = 40;
    rem[1] = 3;
    run(8);

    // randomized traffic
    agents_clear();
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0 && $urandom_range(7) == 0) begin
          base[c] = int'($urandom_range(1023));
          served[c] = 0;
          rem[c] = int'($urandom_range(6, 1));
        end
      end
      cyc();
    end
    agents_clear();
    run(5);

    @(negedge clk);
    #1;
    chk("scoreboard_drain", 0, 32'(q0.size() + q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
